// File: rtl/cache_state_array_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_state_array_if                                                     |
// | Lookup, update, flush and writeback signals of the cache state array.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface cache_state_array_if #(
  parameter int INDEXWIDTH = 6,
  parameter int WAYS       = 2
);
  localparam int WAYW = $clog2(WAYS);

  logic                  rd_en;
  logic [INDEXWIDTH-1:0] rd_index;
  logic [WAYS-1:0]       rd_valid;
  logic [WAYS-1:0]       rd_dirty;
  logic [WAYW-1:0]       victim_way;
  logic                  upd_en;
  logic [INDEXWIDTH-1:0] upd_index;
  logic [WAYW-1:0]       upd_way;
  logic                  upd_valid;
  logic                  upd_dirty;
  logic                  upd_touch;
  logic                  flush_req;
  logic                  flush_busy;
  logic                  flush_done;
  logic                  wb_req;
  logic [INDEXWIDTH-1:0] wb_index;
  logic [WAYW-1:0]       wb_way;
  logic                  wb_ack;

  modport master (
    output rd_en, rd_index, upd_en, upd_index, upd_way, upd_valid, upd_dirty,
           upd_touch, flush_req, wb_ack,
    input  rd_valid, rd_dirty, victim_way, flush_busy, flush_done, wb_req,
           wb_index, wb_way
  );

  modport slave (
    input  rd_en, rd_index, upd_en, upd_index, upd_way, upd_valid, upd_dirty,
           upd_touch, flush_req, wb_ack,
    output rd_valid, rd_dirty, victim_way, flush_busy, flush_done, wb_req,
           wb_index, wb_way
  );
endinterface
`default_nettype wire

// File: rtl/cache_state_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_state_array                                                        |
// | Per-set valid/dirty/tree-PLRU state with a flush engine.                 |
// | Define CACHE_FLUSH_WB_EN to build the dirty-line writeback handshake.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cache_state_array #(
  parameter int INDEXWIDTH = 6,
  parameter int WAYS       = 2
) (
  input  logic               clk,
  input  logic               rst,
  cache_state_array_if.slave bus
);
  localparam int SETS  = 2 ** INDEXWIDTH;
  localparam int WAYW  = $clog2(WAYS);
  localparam int SCANW = INDEXWIDTH + WAYW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [WAYS-1:0]       r_valid [SETS];
  logic [WAYS-1:0]       r_dirty [SETS];
  // Heap-ordered tree nodes 1..WAYS-1; bit 0 is never written.
  logic [WAYS-1:0]       r_plru  [SETS];
  logic [SCANW-1:0]      r_scan;
  logic                  r_flush_busy;
  logic                  r_flush_done;

  logic [INDEXWIDTH-1:0] w_scan_index;
  logic [WAYW-1:0]       w_scan_way;
  logic                  w_scan_last;
  logic [WAYS-1:0]       w_sel_valid;
  logic [WAYW-1:0]       w_victim;

  function automatic logic [WAYW-1:0] plru_victim(input logic [WAYS-1:0] tree);
    logic [WAYW:0] node;
    node = (WAYW+1)'(1);
    for (int lvl = 0; lvl < WAYW; lvl++)
      node = {node[WAYW-1:0], tree[node[WAYW-1:0]]};
    return node[WAYW-1:0];
  endfunction

  function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] tree,
                                                 input logic [WAYW-1:0] way);
    logic [WAYS-1:0] t;
    logic [WAYW:0]   node;
    t    = tree;
    node = (WAYW+1)'(1);
    for (int lvl = 0; lvl < WAYW; lvl++) begin
      t[node[WAYW-1:0]] = ~way[WAYW-1-lvl];
      node = {node[WAYW-1:0], way[WAYW-1-lvl]};
    end
    return t;
  endfunction

  assign w_scan_index = r_scan[SCANW-1:WAYW];
  assign w_scan_way   = r_scan[WAYW-1:0];
  assign w_scan_last  = &r_scan;

  always_comb begin
    w_sel_valid = r_valid[bus.rd_index];
    w_victim    = plru_victim(r_plru[bus.rd_index]);
    // Descending walk leaves the lowest invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--)
      if (!w_sel_valid[w]) w_victim = WAYW'(w);
  end

  assign bus.rd_valid   = bus.rd_en ? w_sel_valid : '0;
  assign bus.rd_dirty   = bus.rd_en ? r_dirty[bus.rd_index] : '0;
  assign bus.victim_way = bus.rd_en ? w_victim : '0;
  assign bus.flush_busy = r_flush_busy;
  assign bus.flush_done = r_flush_done;

`ifdef CACHE_FLUSH_WB_EN
  logic                  r_wb_req;
  logic [INDEXWIDTH-1:0] r_wb_index;
  logic [WAYW-1:0]       r_wb_way;

  assign bus.wb_req   = r_wb_req;
  assign bus.wb_index = r_wb_index;
  assign bus.wb_way   = r_wb_way;
`else
  logic w_unused_wb_ack;

  assign w_unused_wb_ack = bus.wb_ack;
  assign bus.wb_req      = 1'b0;
  assign bus.wb_index    = '0;
  assign bus.wb_way      = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_scan       <= '0;
      r_flush_busy <= 1'b0;
      r_flush_done <= 1'b0;
`ifdef CACHE_FLUSH_WB_EN
      r_wb_req     <= 1'b0;
      r_wb_index   <= '0;
      r_wb_way     <= '0;
`endif
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.upd_en) begin
            r_valid[bus.upd_index][bus.upd_way] <= bus.upd_valid;
            r_dirty[bus.upd_index][bus.upd_way] <= bus.upd_valid & bus.upd_dirty;
            if (bus.upd_touch)
              r_plru[bus.upd_index] <= plru_touch(r_plru[bus.upd_index], bus.upd_way);
          end
          if (bus.flush_req) begin
            r_state      <= S_SCAN;
            r_scan       <= '0;
            r_flush_busy <= 1'b1;
          end
        end
        S_SCAN: begin
`ifdef CACHE_FLUSH_WB_EN
          if (r_valid[w_scan_index][w_scan_way] && r_dirty[w_scan_index][w_scan_way]) begin
            r_state    <= S_WB;
            r_wb_req   <= 1'b1;
            r_wb_index <= w_scan_index;
            r_wb_way   <= w_scan_way;
          end else begin
            r_valid[w_scan_index][w_scan_way] <= 1'b0;
            r_dirty[w_scan_index][w_scan_way] <= 1'b0;
            r_scan <= r_scan + SCANW'(1);
            if (w_scan_last) begin
              r_state      <= S_DONE;
              r_flush_done <= 1'b1;
            end
          end
`else
          r_valid[w_scan_index][w_scan_way] <= 1'b0;
          r_dirty[w_scan_index][w_scan_way] <= 1'b0;
          r_scan <= r_scan + SCANW'(1);
          if (w_scan_last) begin
            r_state      <= S_DONE;
            r_flush_done <= 1'b1;
          end
`endif
        end
`ifdef CACHE_FLUSH_WB_EN
        S_WB: begin
          if (bus.wb_ack) begin
            r_valid[w_scan_index][w_scan_way] <= 1'b0;
            r_dirty[w_scan_index][w_scan_way] <= 1'b0;
            r_wb_req   <= 1'b0;
            r_wb_index <= '0;
            r_wb_way   <= '0;
            r_scan     <= r_scan + SCANW'(1);
            if (w_scan_last) begin
              r_state      <= S_DONE;
              r_flush_done <= 1'b1;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end
`endif
        S_DONE: begin
          r_flush_done <= 1'b0;
          r_flush_busy <= 1'b0;
          r_state      <= S_IDLE;
          for (int s = 0; s < SETS; s++)
            r_plru[s] <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cache_state_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cache_state_array                                                     |
// | Directed self-checking bench for cache_state_array (either build).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cache_state_array;
  localparam int INDEXWIDTH = 6;
  localparam int WAYS       = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  cache_state_array_if #(.INDEXWIDTH(INDEXWIDTH), .WAYS(WAYS)) bus ();

  cache_state_array #(.INDEXWIDTH(INDEXWIDTH), .WAYS(WAYS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int idx, input int way, input logic v, input logic d, input logic t);
    bus.upd_en    = 1'b1;
    bus.upd_index = INDEXWIDTH'(idx);
    bus.upd_way   = 1'(way);
    bus.upd_valid = v;
    bus.upd_dirty = d;
    bus.upd_touch = t;
    tick();
    bus.upd_en    = 1'b0;
  endtask

  task automatic rd(input int idx);
    bus.rd_index = INDEXWIDTH'(idx);
    #1;
  endtask

  initial begin
    int busy_cycles, done_cnt, guard, ep, agg;
    logic wb_seen;
    int exp_idx [2];
    int exp_way [2];
    exp_idx = '{2, 63};
    exp_way = '{1, 0};

    bus.rd_en = 1'b1; bus.rd_index = INDEXWIDTH'(5);
    bus.upd_en = 1'b0; bus.upd_index = '0; bus.upd_way = '0;
    bus.upd_valid = 1'b0; bus.upd_dirty = 1'b0; bus.upd_touch = 1'b0;
    bus.flush_req = 1'b0; bus.wb_ack = 1'b0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_valid", 32'(bus.rd_valid), 32'h0);
    check("reset_dirty", 32'(bus.rd_dirty), 32'h0);
    check("reset_victim", 32'(bus.victim_way), 32'h0);
    check("reset_busy", 32'(bus.flush_busy), 32'h0);
    check("reset_wbreq", 32'(bus.wb_req), 32'h0);

    // Fill set 3 and follow the PLRU pointer
    upd(3, 0, 1'b1, 1'b0, 1'b1); rd(3);
    check("fill0_valid", 32'(bus.rd_valid), 32'h1);
    check("fill0_victim", 32'(bus.victim_way), 32'h1);
    upd(3, 1, 1'b1, 1'b0, 1'b1); rd(3);
    check("fill1_valid", 32'(bus.rd_valid), 32'h3);
    check("fill1_victim", 32'(bus.victim_way), 32'h0);
    upd(3, 0, 1'b1, 1'b0, 1'b1); rd(3);
    check("touch0_victim", 32'(bus.victim_way), 32'h1);
    bus.rd_en = 1'b0; #1;
    check("rden0_valid", 32'(bus.rd_valid), 32'h0);
    check("rden0_victim", 32'(bus.victim_way), 32'h0);
    bus.rd_en = 1'b1;

    // Read-during-write returns old state
    bus.upd_en = 1'b1; bus.upd_index = INDEXWIDTH'(7); bus.upd_way = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_dirty = 1'b0; bus.upd_touch = 1'b0;
    rd(7);
    check("rdw_old", 32'(bus.rd_valid), 32'h0);
    tick(); bus.upd_en = 1'b0; #1;
    check("rdw_new", 32'(bus.rd_valid), 32'h2);
    check("rdw_victim", 32'(bus.victim_way), 32'h0);

    upd(9, 0, 1'b1, 1'b1, 1'b0); rd(9);
    check("dirty_set", 32'(bus.rd_dirty), 32'h1);
    upd(9, 0, 1'b0, 1'b1, 1'b0); rd(9);
    check("inval_dirty", 32'(bus.rd_dirty), 32'h0);
    check("inval_valid", 32'(bus.rd_valid), 32'h0);

    upd(2, 1, 1'b1, 1'b1, 1'b0);
    upd(63, 0, 1'b1, 1'b1, 1'b0); rd(63);
    check("setup63_dirty", 32'(bus.rd_dirty), 32'h1);

    // Flush started together with an update in IDLE
    bus.flush_req = 1'b1;
    bus.upd_en = 1'b1; bus.upd_index = INDEXWIDTH'(5); bus.upd_way = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_dirty = 1'b0; bus.upd_touch = 1'b0;
    tick();
    bus.flush_req = 1'b0; bus.upd_en = 1'b0;
    rd(5);
    check("flush_busy_on", 32'(bus.flush_busy), 32'h1);
    check("flush_upd_same", 32'(bus.rd_valid), 32'h2);

    busy_cycles = 0; done_cnt = 0; guard = 0; ep = 0; wb_seen = 1'b0;
    while (bus.flush_busy && guard < 600) begin
      busy_cycles++; guard++;
      if (bus.flush_done) done_cnt++;
      if (busy_cycles == 5) begin
        bus.upd_en = 1'b1; bus.upd_index = '0; bus.upd_way = 1'b0;
        bus.upd_valid = 1'b1; bus.upd_dirty = 1'b1; bus.upd_touch = 1'b1;
      end
      if (busy_cycles == 10) begin
        rd(3); check("partial_set3", 32'(bus.rd_valid), 32'h0);
        rd(7); check("partial_set7", 32'(bus.rd_valid), 32'h2);
      end
`ifdef CACHE_FLUSH_WB_EN
      if (bus.wb_req) begin
        if (ep < 2) begin
          check("wb_index", 32'(bus.wb_index), 32'(exp_idx[ep]));
          check("wb_way", 32'(bus.wb_way), 32'(exp_way[ep]));
        end
        for (int k = 0; k < 3; k++) begin
          agg = {bus.wb_req, bus.wb_index, bus.wb_way};
          tick();
          check("wb_stable", 32'({bus.wb_req, bus.wb_index, bus.wb_way}), 32'(agg));
        end
        bus.wb_ack = 1'b1; tick(); bus.wb_ack = 1'b0; #1;
        check("wb_req_drop", 32'(bus.wb_req), 32'h0);
        ep++;
      end else begin
        tick();
      end
`else
      if (bus.wb_req) wb_seen = 1'b1;
      tick();
`endif
    end
    bus.upd_en = 1'b0;
    check("flush_finished", 32'(bus.flush_busy), 32'h0);
    check("flush_done_cnt", 32'(done_cnt), 32'h1);
    check("flush_done_low", 32'(bus.flush_done), 32'h0);
`ifdef CACHE_FLUSH_WB_EN
    check("wb_episodes", 32'(ep), 32'h2);
`else
    check("flush_cycles", 32'(busy_cycles), 32'd129);
    check("wb_req_idle", 32'(wb_seen), 32'h0);
`endif
    agg = 0;
    for (int s = 0; s < 64; s++) begin
      rd(s);
      agg = agg | 32'({bus.rd_valid, bus.rd_dirty});
    end
    check("post_flush_all_zero", 32'(agg), 32'h0);

    // PLRU must have been cleared by the flush
    upd(3, 0, 1'b1, 1'b0, 1'b0);
    upd(3, 1, 1'b1, 1'b0, 1'b0); rd(3);
    check("plru_cleared", 32'(bus.victim_way), 32'h0);

    // Reset in the middle of a flush
    upd(1, 0, 1'b1, 1'b1, 1'b0);
    bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0;
`ifdef CACHE_FLUSH_WB_EN
    guard = 0;
    while (!bus.wb_req && guard < 50) begin tick(); guard++; end
    check("mid_wb_req_seen", 32'(bus.wb_req), 32'h1);
`else
    for (int k = 0; k < 5; k++) tick();
    check("mid_busy_seen", 32'(bus.flush_busy), 32'h1);
`endif
    rst = 1'b1; tick(); rst = 1'b0; #1;
    check("mid_rst_wbreq", 32'(bus.wb_req), 32'h0);
    check("mid_rst_busy", 32'(bus.flush_busy), 32'h0);
    done_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus.flush_done || bus.flush_busy) done_cnt++;
      tick();
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'h0);
    rd(1);
    check("mid_rst_cleared", 32'(bus.rd_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cache_state_array.md
Name: cache_state_array

Overview:
- Per-set valid, dirty and tree-PLRU replacement state for an N-way set-associative cache; next generation of the single-way valid bit array.
- Sits beside the tag/data SRAMs in the cache controller.
- Provides combinational lookup of V/D plus a victim way, and registered updates.
- Contains a flush engine: walks every set/way, hands dirty lines to the controller through a req/ack writeback handshake, then invalidates the line.

Parameters:
- INDEXWIDTH, 6, set index width; SETS = 2**INDEXWIDTH (derived, not overridable).
- WAYS, 2, associativity; power of two, 2..8.
- WAYW, $clog2(WAYS), way-number width (derived).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- rd_en  input  1  lookup enable.
- rd_index  input  INDEXWIDTH  lookup set.
- rd_valid  output  WAYS  valid bits of set rd_index.
- rd_dirty  output  WAYS  dirty bits of set rd_index.
- victim_way  output  WAYW  replacement way for set rd_index.
- upd_en  input  1  state update strobe.
- upd_index  input  INDEXWIDTH  update set.
- upd_way  input  WAYW  update way.
- upd_valid  input  1  new valid value.
- upd_dirty  input  1  new dirty value.
- upd_touch  input  1  mark upd_way most-recently-used in PLRU.
- flush_req  input  1  start-flush pulse.
- flush_busy  output  1  flush in progress.
- flush_done  output  1  one-cycle completion pulse.
- wb_req  output  1  dirty line needs writeback.
- wb_index  output  INDEXWIDTH  writeback set.
- wb_way  output  WAYW  writeback way.
- wb_ack  input  1  writeback accepted.

Behaviour:
- Storage:
  - Per set: WAYS valid bits, WAYS dirty bits, WAYS-1 PLRU bits.
  - All registers written only at posedge clk.
- Reset: all V/D/PLRU bits 0, FSM IDLE, scan counter 0. flush_busy, flush_done, wb_req, wb_index and wb_way are 0. A reset mid-flush aborts the flush; no flush_done is issued.
- Read path (combinational, zero latency):
  - rd_en=0: rd_valid, rd_dirty and victim_way are all 0.
  - rd_en=1: rd_valid/rd_dirty reflect the registered state.
  - victim_way = lowest-numbered invalid way if any; otherwise the PLRU way.
- PLRU tree:
  - Node bit 0 means the victim lies in the lower half, 1 the upper half.
  - On touch of way w, every node on w's path is set to point away from w.
- Update:
  - upd_en=1 in IDLE writes V[upd_index][upd_way]=upd_valid and D=upd_dirty at the next edge.
  - If upd_touch=1, PLRU for upd_index is updated in the same edge.
  - upd_valid=0 forces D=0 regardless of upd_dirty.
  - Read of the same set in the same cycle returns old state; new state is visible the following cycle.
- FSM states IDLE, SCAN, WB, DONE:
  - IDLE: flush_req=1 -> SCAN with counter {index=0, way=0} and flush_busy=1 from the next cycle.
  - SCAN (one entry per cycle):
    - If the entry is valid and dirty: -> WB, with wb_req=1 and wb_index/wb_way = counter.
    - Otherwise: clear V/D of the entry and advance the counter (way first, then index).
    - Leaving the last entry (index=SETS-1, way=WAYS-1) -> DONE.
  - WB: wb_req, wb_index and wb_way are held stable until wb_ack=1. On that edge: clear V/D, advance the counter, go -> SCAN, or -> DONE if it was the last entry. wb_ack outside WB is ignored.
  - DONE: flush_done=1 for exactly one cycle; PLRU bits of all sets cleared; -> IDLE; flush_busy=0 from the next cycle.
- While flush_busy=1:
  - upd_en and flush_req are ignored.
  - Reads remain functional and show partially flushed state.
- flush_req and upd_en together in IDLE: the update is performed and the flush starts.

Optional Feature:
- Macro: CACHE_FLUSH_WB_EN.
- Defined: behaviour as above, with writeback handshake on dirty entries.
- Undefined:
  - The WB state is not built; wb_req, wb_index and wb_way are tied 0 and wb_ack is unused.
  - SCAN clears every entry unconditionally; a flush takes exactly SETS*WAYS SCAN cycles, then DONE.

Test Plan:
- Reset: assert rst 2 cycles; with rd_en=1 and rd_index=5 -> rd_valid=2'b00, rd_dirty=2'b00, victim_way=0; flush_busy=0.
- Fill and victim: upd set 3 way0 (V=1, touch) -> victim_way=1. Then upd way1 (V=1, touch) -> victim_way=0. Then touch way0 -> victim_way=1.
- Read-during-write: upd_en to set 7 way1 with V=1 and rd_index=7 in the same cycle -> rd_valid=2'b00 that cycle, 2'b10 next cycle.
- Dirty invalidate: upd set 9 way0 with V=0, D=1 -> rd_dirty[0]=0.
- Flush with writeback (macro on):
  - Setup: dirty lines at set 2 way1 and set 63 way0; wb_ack 3 cycles after each wb_req.
  - Required: exactly two wb_req episodes, (2,1) then (63,0), each held stable until ack.
  - Then flush_done pulses once, and all sets read 0.
  - upd_en during the flush has no effect.
- Reset mid-flush and macro off:
  - rst asserted during WB -> wb_req=0 and flush_busy=0 next cycle; no flush_done.
  - With the macro off, flush completes in 128 SCAN cycles + 1 DONE cycle, and wb_req stays 0 throughout.
